opti_out_capture: RTL



---
 rtl/opti_pkg.sv | 17 +
 rtl/opti_cap_ram.sv | 37 +++
 rtl/opti_out_capture.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/opti_pkg.sv
// Shared types and widths for the opti filter output capture path.
package opti_pkg;

    localparam int unsigned OPTI_DW     = 24;
    localparam int unsigned OPTI_AW     = 11;
    localparam int unsigned OPTI_SKIP_W = 16;

    typedef logic signed [OPTI_DW-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/opti_cap_ram.sv
// Simple dual-port sample buffer: one write port, one registered read-first read port.
module opti_cap_ram #(
    parameter int unsigned DW = 24,
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned WORDS = 2 ** AW;

    logic [DW-1:0] mem [WORDS];

    // Array is deliberately not reset so captured frames survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the old word gives read-first on address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/opti_out_capture.sv
// Captures a frame of filtered samples into an on-chip buffer for address readback.
// Optional OUT_CAPTURE_PEAK_EN adds a per-frame saturated |sample| peak output.
module opti_out_capture
    import opti_pkg::*;
#(
    parameter int unsigned DW    = OPTI_DW,
    parameter int unsigned AW    = OPTI_AW,
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned SKIP  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic          data_in_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_valid,
    output logic [AW-1:0] wr_addr,
    output logic          capture_done,
    output logic          busy,
    output logic          overflow
`ifdef OUT_CAPTURE_PEAK_EN
    ,
    output logic [DW-1:0] peak_abs
`endif
);

    localparam int unsigned SKIP_W = OPTI_SKIP_W;
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP - 1);
    localparam cap_state_t        ARM_STATE = (SKIP > 0) ? ST_SKIP : ST_CAPTURE;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_cnt_d;
    logic [AW-1:0]     wr_addr_d;
    logic              overflow_d;
    logic              wr_en_c;
    logic              rd_zero_c;

    assign rd_zero_c = 32'(rd_addr) >= DEPTH;

    // Next-state and write control; start overrides everything and drops its coincident sample.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt;
        wr_addr_d  = wr_addr;
        overflow_d = overflow;
        wr_en_c    = 1'b0;

        if (start) begin
            state_d    = ARM_STATE;
            skip_cnt_d = '0;
            wr_addr_d  = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_SKIP: begin
                    if (data_in_valid) begin
                        skip_cnt_d = skip_cnt + SKIP_W'(1);
                        if (skip_cnt == SKIP_LAST) begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (data_in_valid) begin
                        wr_en_c = rst_n;
                        if (wr_addr == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            wr_addr_d = wr_addr + AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (data_in_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and status registers; busy/capture_done track the registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            skip_cnt      <= '0;
            wr_addr       <= '0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
            capture_done  <= 1'b0;
            rd_data_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt      <= skip_cnt_d;
            wr_addr       <= wr_addr_d;
            overflow      <= overflow_d;
            busy          <= (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
            capture_done  <= (state_d == ST_DONE);
            rd_data_valid <= rd_en;
        end
    end

    opti_cap_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_en   (rd_en),
        .rd_zero (rd_zero_c),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef OUT_CAPTURE_PEAK_EN
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] abs_c;

    // Most-negative input has no positive twin, so it saturates.
    always_comb begin
        abs_c = data_in;
        if (data_in == MIN_NEG) begin
            abs_c = MAX_POS;
        end else if (data_in[DW-1]) begin
            abs_c = ~data_in + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_abs <= '0;
        end else if (start) begin
            peak_abs <= '0;
        end else if (wr_en_c && (abs_c > peak_abs)) begin
            peak_abs <= abs_c;
        end
    end
`endif

endmodule
